// File: rtl/matgen_if.sv
// Handshake bundle between matgen_ctrl and its XOF, parse and matrix-RAM neighbours.
// master = controller side, slave = XOF/parse/RAM side.
interface matgen_if #(
  parameter int COEF_W = 12,
  parameter int ADDR_W = 12
);
  logic              xof_start;
  logic [7:0]        xof_b0;
  logic [7:0]        xof_b1;
  logic              xof_done;
  logic              parse_rst;
  logic              parse_start;
  logic              parse_done;
  logic [7:0]        coef_idx;
  logic [COEF_W-1:0] coef_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [COEF_W-1:0] mem_wdata;

  modport master (
    output xof_start, xof_b0, xof_b1, parse_rst, parse_start,
           coef_idx, mem_we, mem_addr, mem_wdata,
    input  xof_done, parse_done, coef_in
  );

  modport slave (
    input  xof_start, xof_b0, xof_b1, parse_rst, parse_start,
           coef_idx, mem_we, mem_addr, mem_wdata,
    output xof_done, parse_done, coef_in
  );
endinterface

// File: rtl/matgen_ctrl.sv
// Sequences generation of the K x K public matrix A: per entry it requests XOF bytes,
// restarts the parse sampler and copies its N coefficients into matrix RAM slot i*K+j.
module matgen_ctrl #(
  parameter int K       = 3,
  parameter int N       = 256,
  parameter int COEF_W  = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start_i,
  input  logic     transpose_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     err_o,
  matgen_if.master bus
);
  localparam int ADDR_W = $clog2(K*K*N);
  localparam int IW     = $clog2(K) + 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    XOF_REQ  = 4'd1,
    XOF_WAIT = 4'd2,
    P_RST    = 4'd3,
    P_START  = 4'd4,
    P_WAIT   = 4'd5,
    COPY     = 4'd6,
    NEXT     = 4'd7,
    DONE     = 4'd8,
    ERR      = 4'd9
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [7:0]    c_q, c_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tr_q, tr_d;
  logic          err_q, err_d;
  logic [ADDR_W-1:0] slot_base;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= {IW{1'b0}};
      j_q     <= {IW{1'b0}};
      c_q     <= 8'd0;
      tmo_q   <= {TW{1'b0}};
      tr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      c_q     <= c_d;
      tmo_q   <= tmo_d;
      tr_q    <= tr_d;
      err_q   <= err_d;
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    c_d     = c_q;
    tmo_d   = tmo_q;
    tr_d    = tr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tr_d    = transpose_i;
          i_d     = {IW{1'b0}};
          j_d     = {IW{1'b0}};
          err_d   = 1'b0;
          state_d = XOF_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      XOF_REQ: state_d = XOF_WAIT;
      XOF_WAIT: begin
        if (bus.xof_done) begin
          state_d = P_RST;
        end else begin
          state_d = XOF_WAIT;
        end
      end
      P_RST: state_d = P_START;
      P_START: begin
        tmo_d   = {TW{1'b0}};
        state_d = P_WAIT;
      end
      P_WAIT: begin
        // parse_done takes priority over a coincident timeout
        if (bus.parse_done) begin
          c_d     = 8'd0;
          state_d = COPY;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          tmo_d   = tmo_q + TW'(1'b1);
          state_d = P_WAIT;
        end
      end
      COPY: begin
        if (c_q == 8'(N - 1)) begin
          c_d     = 8'd0;
          state_d = NEXT;
        end else begin
          c_d     = c_q + 8'd1;
          state_d = COPY;
        end
      end
      NEXT: begin
        if (j_q == IW'(K - 1)) begin
          j_d = {IW{1'b0}};
          i_d = i_q + IW'(1'b1);
          if (i_q == IW'(K - 1)) begin
            state_d = DONE;
          end else begin
            state_d = XOF_REQ;
          end
        end else begin
          j_d     = j_q + IW'(1'b1);
          state_d = XOF_REQ;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign slot_base = (ADDR_W'(i_q) * ADDR_W'(K) + ADDR_W'(j_q)) * ADDR_W'(N);

  assign busy_o = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

  // b0/b1 come straight from the held indices, so they stay stable for the whole entry
  assign bus.xof_start   = (state_q == XOF_REQ);
  assign bus.xof_b0      = tr_q ? 8'(i_q) : 8'(j_q);
  assign bus.xof_b1      = tr_q ? 8'(j_q) : 8'(i_q);
  assign bus.parse_rst   = rst | (state_q == P_RST);
  assign bus.parse_start = (state_q == P_START);
  assign bus.mem_we      = (state_q == COPY);
  assign bus.coef_idx    = (state_q == COPY) ? c_q : 8'd0;
  assign bus.mem_addr    = (state_q == COPY) ? (slot_base + ADDR_W'(c_q)) : {ADDR_W{1'b0}};
  assign bus.mem_wdata   = (state_q == COPY) ? bus.coef_in : {COEF_W{1'b0}};
endmodule
